mul_div_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns all writes into the HI/LO register pair. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the execute stage and computes products and quotients iteratively. It drives the HI/LO write-enable and data buses, and holds `busy` high so the pipeline stalls until the result is written.

---
 rtl/mul_div_ctrl.sv | 130 +++++++++++++
 tb/tb_mul_div_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: iterative multiply/divide sequencer that owns every HI/LO register write.
module mul_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             op_ready,
  output logic             busy,
  output logic [1:0]       we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(ITER);
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4,
                         OP_MTHI = 3'd5, OP_MTLO = 3'd6;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, WR} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
  logic [WIDTH:0] mul_hi, trial;
  logic [1:0] we_q, we_d;
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d, div_q, div_d;
  logic sgn, is_div, is_mt, legal, last;
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
  assign legal  = (op != 3'd0) && (op != 3'd7);
  assign a_mag  = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag  = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
  assign last   = cnt_q == CW'(ITER - 1);
  // Low half of acc holds the multiplier (MUL) or the dividend shifting into quotient (DIV).
  assign mul_hi = acc_q[0] ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q} : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign trial  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
  assign prod   = neg_quo_q ? -acc_q : acc_q;
  assign quo    = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    div_d     = div_q;
    we_d      = 2'b00;
    case (state_q)
      IDLE: if (op_valid && !flush && legal) begin
        a_d   = src_a;
        cnt_d = '0;
        if (is_mt) begin
          we_d    = (op == OP_MTHI) ? 2'b10 : 2'b01;
          hi_d    = src_a;
          lo_d    = src_a;
          state_d = WR;
        end else begin
          neg_quo_d = sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_rem_d = sgn && src_a[WIDTH-1];
          div_d     = is_div;
          dz_d      = is_div && (src_b == '0);
          m_d       = is_div ? b_mag : a_mag;
          acc_d     = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
          state_d   = is_div ? DIV : MUL;
        end
      end
      MUL: begin
        acc_d   = {mul_hi, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        state_d = flush ? IDLE : last ? FIX : MUL;
      end
      DIV: begin
        acc_d   = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d   = cnt_q + CW'(1);
        state_d = flush ? IDLE : last ? FIX : DIV;
      end
      FIX: begin
        hi_d    = dz_q ? a_q : div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d    = dz_q ? '1 : div_q ? quo : prod[WIDTH-1:0];
        we_d    = flush ? 2'b00 : 2'b11;
        state_d = flush ? IDLE : WR;
      end
      WR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      div_q     <= 1'b0;
      we_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      div_q     <= div_d;
      we_q      <= we_d;
    end
  end
  assign op_ready = state_q == IDLE;
  assign busy     = state_q != IDLE;
  assign we       = we_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
endmodule

// File: tb/tb_mul_div_ctrl.sv
// tb_mul_div_ctrl: scoreboard bench for mul_div_ctrl timing, results, flush and reset.
module tb_mul_div_ctrl;
  logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] src_a = '0, src_b = '0, hi_o, lo_o;
  logic op_ready, busy;
  logic [1:0] we;
  int cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct {logic [1:0] we; logic [31:0] hi, lo; int cyc;} exp_t;
  exp_t sb[$];

  mul_div_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .op_ready(op_ready), .busy(busy), .we(we), .hi_o(hi_o), .lo_o(lo_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    case (o)
      3'd1: return 64'($signed(longint'($signed(a)) * longint'($signed(b))));
      3'd2: return {32'b0, a} * {32'b0, b};
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && we != 2'b00) begin
      if (sb.size() == 0) chk("spurious_we", 64'(we), 64'(0));
      else begin
        e = sb.pop_front();
        chk("we", 64'(we), 64'(e.we));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        if (e.we[1]) chk("hi", 64'(hi_o), 64'(e.hi));
        if (e.we[0]) chk("lo", 64'(lo_o), 64'(e.lo));
      end
    end
  end

  // Called just after a negedge; returns at the negedge of the first IDLE cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] ewe, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat, input int fc);
    int last_busy, n;
    exp_t e;
    last_busy = (fc > 0 && fc < lat) ? fc : lat;
    n = last_busy + 1;
    chk("op_ready_pre", 64'(op_ready), 64'(1));
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    flush = (fc == 1);
    if (last_busy == lat) begin
      e.we = ewe; e.hi = ehi; e.lo = elo; e.cyc = cyc + lat - 1;
      sb.push_back(e);
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("busy", 64'(busy), 64'(k <= last_busy));
      if (last_busy != lat) chk("flush_we", 64'(we), 64'(0));
      if (k == n) chk("op_ready", 64'(op_ready), 64'(1));
      if (k < n) begin
        @(posedge clk); #1;
        flush = (k + 1 == fc);
      end
    end
  endtask

  initial begin
    logic [2:0] ro;
    logic [31:0] ra, rb;
    logic [63:0] m;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(op_ready), 64'(1));
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_hi", 64'(hi_o), 64'(0));
    chk("rst_lo", 64'(lo_o), 64'(0));
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 2'b11, 32'h00000001, 32'hFFFFFFFE, 34, 0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 0);
    run_op(3'd4, 32'd7, 32'd0, 2'b11, 32'd7, 32'hFFFFFFFF, 34, 0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd0, 2'b11, 32'hFFFFFFF9, 32'hFFFFFFFF, 34, 0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 2'b11, 32'h0, 32'h80000000, 34, 0);
    run_op(3'd3, 32'd100, 32'd7, 2'b11, 32'd2, 32'd14, 34, 10);
    run_op(3'd3, 32'd100, 32'd7, 2'b11, 32'd2, 32'd14, 34, 34);
    run_op(3'd5, 32'h12345678, 32'd0, 2'b10, 32'h12345678, 32'h0, 1, 0);
    run_op(3'd6, 32'h9ABCDEF0, 32'd0, 2'b01, 32'h0, 32'h9ABCDEF0, 1, 0);
    // reset in cycle 20 of a MULT, after LO was loaded with a nonzero value
    op_valid = 1'b1; op = 3'd1; src_a = 32'd5; src_b = 32'd3;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(op_ready), 64'(1));
    chk("midrst_we", 64'(we), 64'(0));
    chk("midrst_hi", 64'(hi_o), 64'(0));
    chk("midrst_lo", 64'(lo_o), 64'(0));
    repeat (36) begin @(negedge clk); chk("midrst_nowr", 64'(we), 64'(0)); end
    op_valid = 1'b1; op = 3'd7; src_a = 32'd9; src_b = 32'd3;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (3) begin @(negedge clk); chk("illegal_busy", 64'(busy), 64'(0)); end
    op_valid = 1'b1; op = 3'd2; flush = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0; flush = 1'b0;
    repeat (3) begin @(negedge clk); chk("idleflush_busy", 64'(busy), 64'(0)); end
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, 2'b11, m[63:32], m[31:0], 34, 0);
    end
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
